// File: rtl/rob_retire_head.sv
// rob_retire_head: reorder buffer with a 3-wide dispatch tail and a 3-wide in-order retire head.
// Dispatch writes up to three entries per cycle at the tail. The CDB marks entries complete.
// The oldest completed entries are offered to stage_rt as a 3-lane packet with zero latency.
// Retirement stops at the first taken branch or halt. squash_flag from stage_rt flushes the ROB.
// Optional build macro ROB_RETIRE_CNT_EN adds a 64-bit retired_count output.

`ifndef XLEN
`define XLEN 32
`endif

package rob_retire_head_pkg;
  // Tag field width of the retire packet. It is wide enough for any ROB up to 256 entries.
  localparam int RT_TAG_W = 8;

  typedef struct packed {
    logic [4:0]          dest_reg_idx;
    logic [RT_TAG_W-1:0] tag;
    logic [`XLEN-1:0]    value;
    logic                valid;
    logic                take_branch;
    logic [`XLEN-1:0]    NPC;
    logic                halt;
  } ROB_RT_PACKET;
endpackage

module rob_retire_head
  import rob_retire_head_pkg::*;
#(
  parameter  int ROB_SZ = 32,
  localparam int TAG_W  = $clog2(ROB_SZ)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [2:0]                  dp_valid,
  input  logic [2:0][4:0]             dp_dest_reg_idx,
  input  logic [2:0][`XLEN-1:0]       dp_NPC,
  input  logic [2:0]                  dp_halt,
  output logic [2:0][TAG_W-1:0]       dp_tag,
  output logic                        dp_stall,
  output logic [TAG_W:0]              free_slots,
  input  logic [2:0]                  cdb_valid,
  input  logic [2:0][TAG_W-1:0]       cdb_tag,
  input  logic [2:0][`XLEN-1:0]       cdb_value,
  input  logic [2:0]                  cdb_take_branch,
  input  logic                        rt_busy,
  input  logic                        squash_flag,
  output ROB_RT_PACKET [2:0]          rob_rt_packet_out,
  output logic                        empty,
  output logic                        full
`ifdef ROB_RETIRE_CNT_EN
  ,output logic [63:0]                retired_count
`endif
);

  // Pointer and occupancy state. The count keeps full and empty apart when head equals tail.
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;
  logic [ROB_SZ-1:0] r_occ;
  logic [ROB_SZ-1:0] r_done;

  // Entry payload. It is only meaningful while occ (and done, for results) is set.
  logic [4:0]        r_dest  [ROB_SZ];
  logic [`XLEN-1:0]  r_npc   [ROB_SZ];
  logic [`XLEN-1:0]  r_value [ROB_SZ];
  logic [ROB_SZ-1:0] r_take_branch;
  logic [ROB_SZ-1:0] r_halt;

  logic [1:0]            w_n_dp;
  logic [1:0]            w_n_acc;
  logic                  w_dp_accept;
  logic [1:0]            w_n_rt;
  logic [2:0][TAG_W-1:0] w_rt_idx;
  logic [2:0]            w_rt_valid;
  logic [2:0]            w_rt_consume;
  logic                  w_chain;
  logic                  w_stop;

  // Occupancy flags and the free-slot count, taken from registered state only.
  assign empty      = (r_count == '0);
  assign full       = (r_count == (TAG_W+1)'(ROB_SZ));
  assign free_slots = (TAG_W+1)'(ROB_SZ) - r_count;

  // Compact the valid dispatch lanes onto tail, tail+1, ... and count them.
  always_comb begin
    // NOTE: blocking assignments here build a running prefix count within one evaluation; the default first keeps it latch-free.
    w_n_dp = '0;
    for (int i = 0; i < 3; i++) begin
      dp_tag[i] = r_tail + TAG_W'(w_n_dp);
      w_n_dp    = w_n_dp + 2'(dp_valid[i]);
    end
  end

  // All-or-nothing acceptance against the registered free-slot count.
  always_comb begin
    dp_stall    = ((TAG_W+1)'(w_n_dp) > free_slots);
    w_dp_accept = ~dp_stall;
    w_n_acc     = w_dp_accept ? w_n_dp : 2'd0;
  end

  // Build the in-order retire packet and decide how many lanes are consumed this cycle.
  always_comb begin
    w_n_rt       = '0;
    w_stop       = 1'b0;
    w_chain      = ~rt_busy & ~empty;
    w_rt_consume = '0;
    for (int i = 0; i < 3; i++) begin
      w_rt_idx[i]   = r_head + TAG_W'(i);
      w_rt_valid[i] = w_chain & r_occ[w_rt_idx[i]] & r_done[w_rt_idx[i]];
      w_chain       = w_rt_valid[i];

      rob_rt_packet_out[i].dest_reg_idx = r_dest[w_rt_idx[i]];
      rob_rt_packet_out[i].tag          = RT_TAG_W'(w_rt_idx[i]);
      rob_rt_packet_out[i].value        = r_value[w_rt_idx[i]];
      rob_rt_packet_out[i].valid        = w_rt_valid[i];
      rob_rt_packet_out[i].take_branch  = r_take_branch[w_rt_idx[i]];
      rob_rt_packet_out[i].NPC          = r_npc[w_rt_idx[i]];
      rob_rt_packet_out[i].halt         = r_halt[w_rt_idx[i]];

      // A redirect or halt retires but ends the group; younger valid lanes wait.
      if (w_rt_valid[i] && !w_stop) begin
        w_rt_consume[i] = 1'b1;
        w_n_rt          = w_n_rt + 2'd1;
        if (r_take_branch[w_rt_idx[i]] || r_halt[w_rt_idx[i]]) begin
          w_stop = 1'b1;
        end
      end
    end
  end

  // Pointers, count and per-entry occ/done. A squash clears everything. Otherwise the order is complete, retire, dispatch.
  always_ff @(posedge clock) begin
    if (reset || squash_flag) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_occ   <= '0;
      r_done  <= '0;
    end else begin
      r_head  <= r_head + TAG_W'(w_n_rt);
      r_tail  <= r_tail + TAG_W'(w_n_acc);
      r_count <= r_count + (TAG_W+1)'(w_n_acc) - (TAG_W+1)'(w_n_rt);

      // NOTE: several non-blocking writes to one bit in a block resolve to the last one, so later steps override earlier ones.
      for (int k = 0; k < 3; k++) begin
        if (cdb_valid[k] && r_occ[cdb_tag[k]]) begin
          r_done[cdb_tag[k]] <= 1'b1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (w_rt_consume[i]) begin
          r_occ[w_rt_idx[i]]  <= 1'b0;
          r_done[w_rt_idx[i]] <= 1'b0;
        end
      end
      if (w_dp_accept) begin
        for (int i = 0; i < 3; i++) begin
          if (dp_valid[i]) begin
            r_occ[dp_tag[i]]  <= 1'b1;
            r_done[dp_tag[i]] <= 1'b0;
          end
        end
      end
    end
  end

  // Entry payload writes. Dispatch fills the static fields, and the CDB fills the result (higher lane wins).
  always_ff @(posedge clock) begin
    // NOTE: the payload arrays are deliberately not reset; occ/done gate every use, so stale contents are harmless.
    if (!reset && !squash_flag) begin
      for (int k = 0; k < 3; k++) begin
        if (cdb_valid[k] && r_occ[cdb_tag[k]]) begin
          r_value[cdb_tag[k]]       <= cdb_value[k];
          r_take_branch[cdb_tag[k]] <= cdb_take_branch[k];
        end
      end
      if (w_dp_accept) begin
        for (int i = 0; i < 3; i++) begin
          if (dp_valid[i]) begin
            r_dest[dp_tag[i]] <= dp_dest_reg_idx[i];
            r_npc[dp_tag[i]]  <= dp_NPC[i];
            r_halt[dp_tag[i]] <= dp_halt[i];
          end
        end
      end
    end
  end

`ifdef ROB_RETIRE_CNT_EN
  // Lifetime retire counter. Only reset clears it. A squash does not.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_count <= '0;
    end else begin
      retired_count <= retired_count + 64'(w_n_rt);
    end
  end
`endif

endmodule
